regfile_arbiter: RTL

Two-requester round-robin arbiter and sequencer for the 32-entry register file. It shares the register file's single write port and two read ports between two independent requesters. Each accepted transaction is replayed onto the register file controls one cycle later, and the read data is returned registered. It sits between the requesters (for example a datapath and a debug/load port) and the register file instance.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_rr_arb2.sv | 70 +++++++
 rtl/regfile_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file arbiter slice.
package regfile_pkg;

    localparam int AW    = 5;
    localparam int N_DEF = 31;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        HOLD0 = 2'd1,
        HOLD1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/regfile_rr_arb2.sv
// Two-way round-robin grant with lock hold; zero latency, ready combinational from valid.
// A held grant starves the other requester until the holder sends an unlocked beat.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid_i,
    input  logic [1:0] lock_i,
    output logic [1:0] ready_o,
    output logic       owner_o
);

    arb_state_e state_q, state_d;
    logic       prio_q, prio_d;
    logic       acc;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        ready_o = 2'b00;

        unique case (state_q)
            ARB: begin
                if (valid_i[0] && (!valid_i[1] || !prio_q))
                    ready_o[0] = 1'b1;
                else if (valid_i[1])
                    ready_o[1] = 1'b1;
            end
            HOLD0:   ready_o[0] = valid_i[0];
            HOLD1:   ready_o[1] = valid_i[1];
            default: ready_o    = 2'b00;
        endcase

        // No beat is accepted while reset is being applied.
        if (rst)
            ready_o = 2'b00;

        owner_o = ready_o[1];
        acc     = |ready_o;

        if (acc) begin
            unique case (state_q)
                ARB: begin
                    prio_d = ~owner_o;
                    if (lock_i[owner_o])
                        state_d = owner_o ? HOLD1 : HOLD0;
                end
                HOLD0, HOLD1: begin
                    if (!lock_i[owner_o])
                        state_d = ARB;
                end
                default: state_d = ARB;
            endcase
        end else if (state_q != ARB && state_q != HOLD0 && state_q != HOLD1) begin
            state_d = ARB;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares one RF write port and two read ports between two requesters; 2-cycle accept-to-response.
// Backpressure via combinational ready; one beat per cycle, no bubble on grant switch.
module regfile_arbiter
    import regfile_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_lock,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_wa,
    input  logic [N:0]    req0_wdata,
    input  logic [AW-1:0] req0_ra_a,
    input  logic [AW-1:0] req0_ra_b,
    output logic          rsp0_valid,
    output logic [N:0]    rsp0_a,
    output logic [N:0]    rsp0_b,

    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_lock,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_wa,
    input  logic [N:0]    req1_wdata,
    input  logic [AW-1:0] req1_ra_a,
    input  logic [AW-1:0] req1_ra_b,
    output logic          rsp1_valid,
    output logic [N:0]    rsp1_a,
    output logic [N:0]    rsp1_b,

    output logic          rf_we,
    output logic          rf_re_a,
    output logic          rf_re_b,
    output logic [AW-1:0] rf_wa,
    output logic [AW-1:0] rf_ra_a,
    output logic [AW-1:0] rf_ra_b,
    output logic [N:0]    rf_in,
    input  logic [N:0]    rf_out_a,
    input  logic [N:0]    rf_out_b
);

    logic [1:0] ready;
    logic       owner;
    logic       acc;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid_i ({req1_valid, req0_valid}),
        .lock_i  ({req1_lock, req0_lock}),
        .ready_o (ready),
        .owner_o (owner)
    );

    assign req0_ready = ready[0];
    assign req1_ready = ready[1];
    assign acc        = |ready;

    logic          iss_vld_q,   iss_vld_d;
    logic          iss_owner_q, iss_owner_d;
    logic          iss_we_q,    iss_we_d;
    logic [AW-1:0] iss_wa_q,    iss_wa_d;
    logic [AW-1:0] iss_ra_a_q,  iss_ra_a_d;
    logic [AW-1:0] iss_ra_b_q,  iss_ra_b_d;
    logic [N:0]    iss_wdata_q, iss_wdata_d;

    logic [1:0]    rsp_vld_q, rsp_vld_d;
    logic [N:0]    rsp0_a_q, rsp0_a_d, rsp0_b_q, rsp0_b_d;
    logic [N:0]    rsp1_a_q, rsp1_a_d, rsp1_b_q, rsp1_b_d;

    always_comb begin
        iss_vld_d   = acc;
        iss_owner_d = owner;
        iss_we_d    = 1'b0;
        iss_wa_d    = iss_wa_q;
        iss_ra_a_d  = iss_ra_a_q;
        iss_ra_b_d  = iss_ra_b_q;
        iss_wdata_d = iss_wdata_q;
        if (acc) begin
            iss_we_d    = owner ? req1_we    : req0_we;
            iss_wa_d    = owner ? req1_wa    : req0_wa;
            iss_ra_a_d  = owner ? req1_ra_a  : req0_ra_a;
            iss_ra_b_d  = owner ? req1_ra_b  : req0_ra_b;
            iss_wdata_d = owner ? req1_wdata : req0_wdata;
        end
    end

    // Read data is captured on the same edge that commits the write, so a
    // beat reading its own write address returns the pre-write value.
    always_comb begin
        rsp_vld_d = 2'b00;
        rsp0_a_d  = rsp0_a_q;
        rsp0_b_d  = rsp0_b_q;
        rsp1_a_d  = rsp1_a_q;
        rsp1_b_d  = rsp1_b_q;
        if (iss_vld_q) begin
            rsp_vld_d[iss_owner_q] = 1'b1;
            if (iss_owner_q) begin
                rsp1_a_d = rf_out_a;
                rsp1_b_d = rf_out_b;
            end else begin
                rsp0_a_d = rf_out_a;
                rsp0_b_d = rf_out_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_vld_q   <= 1'b0;
            iss_owner_q <= 1'b0;
            iss_we_q    <= 1'b0;
            iss_wa_q    <= '0;
            iss_ra_a_q  <= '0;
            iss_ra_b_q  <= '0;
            iss_wdata_q <= '0;
            rsp_vld_q   <= 2'b00;
            rsp0_a_q    <= '0;
            rsp0_b_q    <= '0;
            rsp1_a_q    <= '0;
            rsp1_b_q    <= '0;
        end else begin
            iss_vld_q   <= iss_vld_d;
            iss_owner_q <= iss_owner_d;
            iss_we_q    <= iss_we_d;
            iss_wa_q    <= iss_wa_d;
            iss_ra_a_q  <= iss_ra_a_d;
            iss_ra_b_q  <= iss_ra_b_d;
            iss_wdata_q <= iss_wdata_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp0_a_q    <= rsp0_a_d;
            rsp0_b_q    <= rsp0_b_d;
            rsp1_a_q    <= rsp1_a_d;
            rsp1_b_q    <= rsp1_b_d;
        end
    end

    // Enables are masked during reset so an in-flight write never commits.
    assign rf_we   = iss_we_q  & ~rst;
    assign rf_re_a = iss_vld_q & ~rst;
    assign rf_re_b = iss_vld_q & ~rst;
    assign rf_wa   = iss_wa_q;
    assign rf_ra_a = iss_ra_a_q;
    assign rf_ra_b = iss_ra_b_q;
    assign rf_in   = iss_wdata_q;

    assign rsp0_valid = rsp_vld_q[0];
    assign rsp1_valid = rsp_vld_q[1];
    assign rsp0_a     = rsp0_a_q;
    assign rsp0_b     = rsp0_b_q;
    assign rsp1_a     = rsp1_a_q;
    assign rsp1_b     = rsp1_b_q;

endmodule
